// File: rtl/mem_port_arbiter.sv
// Two-port arbiter sharing one wait-state memory: registered grant FSM, round-robin or fixed priority.
// Optional watchdog timeout compiled in with MEM_ARB_TIMEOUT_EN.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned PRIO_MODE = 0,
  parameter int unsigned TIMEOUT   = 64
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              p0_re_i,
  input  logic              p0_we_i,
  input  logic [ADDR_W-1:0] p0_add_i,
  input  logic [3:0]        p0_ble_i,
  input  logic [31:0]       p0_d_i,
  output logic [31:0]       p0_d_o,
  output logic              p0_valid_o,
  input  logic              p1_re_i,
  input  logic              p1_we_i,
  input  logic [ADDR_W-1:0] p1_add_i,
  input  logic [3:0]        p1_ble_i,
  input  logic [31:0]       p1_d_i,
  output logic [31:0]       p1_d_o,
  output logic              p1_valid_o,
  output logic              mem_re_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_add_o,
  output logic [3:0]        mem_ble_o,
  output logic [31:0]       mem_d_o,
  input  logic [31:0]       mem_d_i,
  input  logic              mem_valid_i,
  output logic              err_o
);

  localparam logic [31:0] TIMEOUT_WORD = 32'hDEAD_BEEF;

  if (TIMEOUT < 2) begin : g_timeout_range
    $error("mem_port_arbiter: TIMEOUT must be >= 2");
  end

  typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;

  state_t state_q, state_d;
  logic   rr_last_q, rr_last_d;
  logic   req0, req1;
  logic   timeout;

  assign req0 = p0_re_i | p0_we_i;
  assign req1 = p1_re_i | p1_we_i;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int unsigned TMR_W = $clog2(TIMEOUT);

  logic [TMR_W-1:0] timer_q;

  // Counts granted cycles; held at zero while idle so every grant starts fresh.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      timer_q <= '0;
    end else if (state_q == IDLE) begin
      timer_q <= '0;
    end else begin
      timer_q <= timer_q + TMR_W'(1);
    end
  end

  assign timeout = (timer_q == TMR_W'(TIMEOUT - 1));
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      rr_last_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      rr_last_q <= rr_last_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    rr_last_d  = rr_last_q;
    mem_re_o   = 1'b0;
    mem_we_o   = 1'b0;
    mem_add_o  = '0;
    mem_ble_o  = '0;
    mem_d_o    = '0;
    p0_valid_o = 1'b0;
    p0_d_o     = '0;
    p1_valid_o = 1'b0;
    p1_d_o     = '0;
    err_o      = 1'b0;

    case (state_q)
      IDLE: begin
        // Ties go to port 1 in fixed mode, otherwise to the port not served last.
        if (req0 && req1) begin
          if ((PRIO_MODE != 0) || !rr_last_q) begin
            state_d   = GNT1;
            rr_last_d = 1'b1;
          end else begin
            state_d   = GNT0;
            rr_last_d = 1'b0;
          end
        end else if (req0) begin
          state_d   = GNT0;
          rr_last_d = 1'b0;
        end else if (req1) begin
          state_d   = GNT1;
          rr_last_d = 1'b1;
        end
      end

      GNT0: begin
        mem_re_o  = p0_re_i & ~p0_we_i;
        mem_we_o  = p0_we_i;
        mem_add_o = p0_add_i;
        mem_ble_o = p0_ble_i;
        mem_d_o   = p0_d_i;
        if (mem_valid_i) begin
          p0_valid_o = 1'b1;
          p0_d_o     = mem_d_i;
          state_d    = IDLE;
        end else if (timeout) begin
          p0_valid_o = 1'b1;
          p0_d_o     = TIMEOUT_WORD;
          err_o      = 1'b1;
          state_d    = IDLE;
        end
      end

      GNT1: begin
        mem_re_o  = p1_re_i & ~p1_we_i;
        mem_we_o  = p1_we_i;
        mem_add_o = p1_add_i;
        mem_ble_o = p1_ble_i;
        mem_d_o   = p1_d_i;
        if (mem_valid_i) begin
          p1_valid_o = 1'b1;
          p1_d_o     = mem_d_i;
          state_d    = IDLE;
        end else if (timeout) begin
          p1_valid_o = 1'b1;
          p1_d_o     = TIMEOUT_WORD;
          err_o      = 1'b1;
          state_d    = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: round-robin DUT plus a fixed-priority instance.
module tb_mem_port_arbiter;
  localparam int unsigned AW = 32;

  typedef struct {
    int          port;
    logic [31:0] data;
    logic        err;
    int          cyc;
  } rsp_t;

  typedef struct {
    logic        re;
    logic        we;
    logic [31:0] add;
    logic [3:0]  ble;
    logic [31:0] d;
  } mreq_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic          p0_re = 0, p0_we = 0, p1_re = 0, p1_we = 0;
  logic [AW-1:0] p0_add = '0, p1_add = '0;
  logic [3:0]    p0_ble = '0, p1_ble = '0;
  logic [31:0]   p0_d = '0, p1_d = '0;

  logic [31:0]   p0_dout, p1_dout, mem_dout, mem_din;
  logic          p0_valid, p1_valid, mem_re, mem_we, mem_valid, err;
  logic [AW-1:0] mem_add;
  logic [3:0]    mem_ble;

  logic [31:0]   f_p0_dout, f_p1_dout, f_mem_dout;
  logic          f_p0_valid, f_p1_valid, f_mem_re, f_mem_we, f_mem_valid, f_err;
  logic [AW-1:0] f_mem_add;
  logic [3:0]    f_mem_ble;

  int checks = 0;
  int fails = 0;
  int cyc = 0;
  int ws = 1;
  bit stall = 1'b0;
  int wcnt = 0;
  int f_wcnt = 0;
  int rsp_seen = 0;
  int f_p0_cnt = 0;
  int f_p1_cnt = 0;
  bit fp_watch = 1'b0;
  logic [31:0] mem_arr [256];
  rsp_t  rsp_q [$];
  mreq_t mreq_q [$];
  rsp_t  e;
  mreq_t m;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(AW), .PRIO_MODE(0), .TIMEOUT(8)) u_dut (
    .clk_i(clk), .rst_i(rst),
    .p0_re_i(p0_re), .p0_we_i(p0_we), .p0_add_i(p0_add), .p0_ble_i(p0_ble), .p0_d_i(p0_d),
    .p0_d_o(p0_dout), .p0_valid_o(p0_valid),
    .p1_re_i(p1_re), .p1_we_i(p1_we), .p1_add_i(p1_add), .p1_ble_i(p1_ble), .p1_d_i(p1_d),
    .p1_d_o(p1_dout), .p1_valid_o(p1_valid),
    .mem_re_o(mem_re), .mem_we_o(mem_we), .mem_add_o(mem_add), .mem_ble_o(mem_ble),
    .mem_d_o(mem_dout), .mem_d_i(mem_din), .mem_valid_i(mem_valid), .err_o(err)
  );

  mem_port_arbiter #(.ADDR_W(AW), .PRIO_MODE(1), .TIMEOUT(8)) u_fp (
    .clk_i(clk), .rst_i(rst),
    .p0_re_i(p0_re), .p0_we_i(p0_we), .p0_add_i(p0_add), .p0_ble_i(p0_ble), .p0_d_i(p0_d),
    .p0_d_o(f_p0_dout), .p0_valid_o(f_p0_valid),
    .p1_re_i(p1_re), .p1_we_i(p1_we), .p1_add_i(p1_add), .p1_ble_i(p1_ble), .p1_d_i(p1_d),
    .p1_d_o(f_p1_dout), .p1_valid_o(f_p1_valid),
    .mem_re_o(f_mem_re), .mem_we_o(f_mem_we), .mem_add_o(f_mem_add), .mem_ble_o(f_mem_ble),
    .mem_d_o(f_mem_dout), .mem_d_i(32'h0), .mem_valid_i(f_mem_valid), .err_o(f_err)
  );

  // Wait-state memory: completes after ws wait cycles of continuous enable.
  assign mem_valid   = (mem_re | mem_we) && (wcnt == ws) && !stall;
  assign mem_din     = (mem_re | mem_we) ? mem_arr[mem_add[9:2]] : 32'h0;
  assign f_mem_valid = (f_mem_re | f_mem_we) && (f_wcnt == ws) && !stall;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (cyc == 0) begin
      for (int i = 0; i < 256; i++) mem_arr[i] <= 32'h0;
      mem_arr[4] <= 32'hCAFE_0010;
    end
    if ((mem_re | mem_we) && !mem_valid) wcnt <= wcnt + 1;
    else wcnt <= 0;
    if ((f_mem_re | f_mem_we) && !f_mem_valid) f_wcnt <= f_wcnt + 1;
    else f_wcnt <= 0;
    if (mem_valid && mem_we)
      for (int b = 0; b < 4; b++)
        if (mem_ble[b]) mem_arr[mem_add[9:2]][8*b +: 8] <= mem_dout[8*b +: 8];
  end

  function automatic void check32(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Response and memory-request monitor.
  always @(negedge clk) begin
    if (!rst) begin
      check32("valid_onehot", 32'(p0_valid & p1_valid), 32'h0);
      if (p0_valid || p1_valid) begin
        rsp_seen++;
        if (rsp_q.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL unexpected_valid: p0=%b p1=%b, none expected", p0_valid, p1_valid);
        end else begin
          e = rsp_q.pop_front();
          check32("rsp_port", 32'(p1_valid), 32'(e.port));
          check32("rsp_data", (e.port == 1) ? p1_dout : p0_dout, e.data);
          check32("rsp_err", 32'(err), 32'(e.err));
          if (e.cyc >= 0) check32("rsp_cycle", 32'(cyc), 32'(e.cyc));
        end
      end else begin
        check32("err_idle", 32'(err), 32'h0);
      end
      if (!p0_valid) check32("p0_d_idle", p0_dout, 32'h0);
      if (!p1_valid) check32("p1_d_idle", p1_dout, 32'h0);
      if (mem_valid) begin
        if (mreq_q.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL unexpected_mem_access: re=%b we=%b add=%h", mem_re, mem_we, mem_add);
        end else begin
          m = mreq_q.pop_front();
          check32("mem_re", 32'(mem_re), 32'(m.re));
          check32("mem_we", 32'(mem_we), 32'(m.we));
          check32("mem_add", mem_add, m.add);
          check32("mem_ble", 32'(mem_ble), 32'(m.ble));
          check32("mem_d", mem_dout, m.d);
        end
      end
      if (fp_watch) begin
        if (f_p0_valid) f_p0_cnt++;
        if (f_p1_valid) f_p1_cnt++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    tick();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic set_port(int port, bit re, bit we, logic [31:0] add, logic [3:0] ble, logic [31:0] d);
    if (port == 0) begin
      p0_re = re; p0_we = we; p0_add = add; p0_ble = ble; p0_d = d;
    end else begin
      p1_re = re; p1_we = we; p1_add = add; p1_ble = ble; p1_d = d;
    end
  endtask

  task automatic push_rsp(int port, logic [31:0] data, logic er, int c);
    rsp_t r;
    r.port = port; r.data = data; r.err = er; r.cyc = c;
    rsp_q.push_back(r);
  endtask

  task automatic push_mreq(logic re, logic we, logic [31:0] add, logic [3:0] ble, logic [31:0] d);
    mreq_t r;
    r.re = re; r.we = we; r.add = add; r.ble = ble; r.d = d;
    mreq_q.push_back(r);
  endtask

  task automatic wait_valid(int port, int budget);
    bit ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      if ((port == 0 && p0_valid) || (port == 1 && p1_valid)) ok = 1'b1;
    end
    if (!ok) begin
      checks++;
      fails++;
      $display("FAIL wait_valid_p%0d: no completion within %0d cycles", port, budget);
    end
  endtask

  // One transaction from idle; expected mem enables and response are hand-supplied.
  task automatic txn(int port, bit re, bit we, logic [31:0] add, logic [3:0] ble,
                     logic [31:0] d, bit exp_re, logic [31:0] exp_d);
    tick();
    set_port(port, re, we, add, ble, d);
    push_mreq(exp_re, we, add, ble, d);
    push_rsp(port, exp_d, 1'b0, cyc + 1 + ws);
    wait_valid(port, 200);
    tick();
    set_port(port, 0, 0, 32'h0, 4'h0, 32'h0);
  endtask

  task automatic check_outputs_zero(string tag);
    check32({tag, "_mem_re"}, 32'(mem_re), 32'h0);
    check32({tag, "_mem_we"}, 32'(mem_we), 32'h0);
    check32({tag, "_mem_add"}, mem_add, 32'h0);
    check32({tag, "_mem_ble"}, 32'(mem_ble), 32'h0);
    check32({tag, "_mem_d"}, mem_dout, 32'h0);
    check32({tag, "_valids"}, 32'({p0_valid, p1_valid}), 32'h0);
    check32({tag, "_p0_d"}, p0_dout, 32'h0);
    check32({tag, "_p1_d"}, p1_dout, 32'h0);
    check32({tag, "_err"}, 32'(err), 32'h0);
  endtask

  initial begin
    int k;
    int n;
    int seen0;

    repeat (3) @(posedge clk);
    #1;
    check_outputs_zero("reset");
    rst = 1'b0;
    tick();
    check_outputs_zero("idle");

    // Reset asserted while port 1 holds the grant.
    ws = 10;
    tick();
    set_port(1, 1, 0, 32'h0000_0044, 4'hF, 32'h0);
    tick();
    tick();
    check32("gnt1_mem_re", 32'(mem_re), 32'h1);
    check32("gnt1_mem_add", mem_add, 32'h0000_0044);
    #2 rst = 1'b1;
    #1 check_outputs_zero("midreset");
    set_port(1, 0, 0, 32'h0, 4'h0, 32'h0);
    tick();
    rst = 1'b0;
    tick();
    check_outputs_zero("postreset");

    // Port 0 read, 3 wait states.
    ws = 3;
    txn(0, 1, 0, 32'h0000_0010, 4'hF, 32'h0, 1'b1, 32'hCAFE_0010);

    // Port 1 partial write, then read back through port 0.
    ws = 2;
    txn(1, 0, 1, 32'h0001_0004, 4'b0011, 32'hA5A5_1234, 1'b0, 32'h0);
    txn(0, 1, 0, 32'h0001_0004, 4'hF, 32'h0, 1'b1, 32'h0000_1234);

    // Port 0 read+write together behaves as a write.
    ws = 0;
    txn(0, 1, 1, 32'h0000_0020, 4'hF, 32'h1357_9BDF, 1'b0, 32'h0);
    txn(1, 1, 0, 32'h0000_0020, 4'hF, 32'h0, 1'b1, 32'h1357_9BDF);

    // Both ports requesting continuously: alternation vs. fixed priority.
    ws = 1;
    do_reset();
    tick();
    set_port(0, 1, 0, 32'h0000_0010, 4'hF, 32'h0);
    set_port(1, 1, 0, 32'h0001_0004, 4'hF, 32'h0);
    fp_watch = 1'b1;
    k = cyc;
    for (int i = 0; i < 4; i++) begin
      push_rsp(i % 2, (i % 2 == 0) ? 32'hCAFE_0010 : 32'h0000_1234, 1'b0, k + 2 + 3 * i);
      push_mreq(1'b1, 1'b0, (i % 2 == 0) ? 32'h0000_0010 : 32'h0001_0004, 4'hF, 32'h0);
    end
    n = 0;
    for (int i = 0; i < 60 && n < 4; i++) begin
      @(negedge clk);
      if (p0_valid || p1_valid) n++;
    end
    check32("rr_completions", 32'(n), 32'd4);
    tick();
    set_port(0, 0, 0, 32'h0, 4'h0, 32'h0);
    set_port(1, 0, 0, 32'h0, 4'h0, 32'h0);
    fp_watch = 1'b0;
    check32("fp_p1_grants", 32'(f_p1_cnt), 32'd4);
    check32("fp_p0_grants", 32'(f_p0_cnt), 32'd0);

    // Memory never answers.
    tick();
    stall = 1'b1;
    set_port(0, 1, 0, 32'h0000_0010, 4'hF, 32'h0);
`ifdef MEM_ARB_TIMEOUT_EN
    push_rsp(0, 32'hDEAD_BEEF, 1'b1, cyc + 8);
    wait_valid(0, 50);
    tick();
    set_port(0, 0, 0, 32'h0, 4'h0, 32'h0);
    stall = 1'b0;
`else
    seen0 = rsp_seen;
    repeat (100) tick();
    check32("stall_no_valid", 32'(rsp_seen - seen0), 32'h0);
    check32("stall_still_granted", 32'(mem_re), 32'h1);
    set_port(0, 0, 0, 32'h0, 4'h0, 32'h0);
    stall = 1'b0;
    do_reset();
`endif
    tick();
    tick();
    check32("rsp_queue_drained", 32'(rsp_q.size()), 32'h0);
    check32("mreq_queue_drained", 32'(mreq_q.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

endmodule
